// File: rtl/bitrev_pkg.sv
// Shared types and sizing helpers for the bit-reverse job controller.
package bitrev_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 1024;

  // Bits needed to hold the value max_val itself.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int TIMEOUT_W = cnt_w(TIMEOUT_DEF);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding accelerator results until the host reads them.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push_s, do_pop_s;

  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  // Head is forced to zero when empty so the output never shows stale data.
  assign dout_o    = empty_o ? '0 : mem_q[rd_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push_s) begin
      wr_d = wr_q + AW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + AW'(1);
    end else begin
      rd_d = rd_q;
    end
    if (do_push_s && !do_pop_s) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (do_pop_s && !do_push_s) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_q] <= din_i;
    end
  end

endmodule

// File: rtl/bitrev_job_ctrl.sv
// Job sequencer for the bit-reverse accelerator: reset hold, input streaming,
// result buffering, completion/stall detection.
module bitrev_job_ctrl
  import bitrev_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEN_W      = 16,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int OUT_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic [DATA_W-1:0] din_i,
  input  logic              din_valid_i,
  output logic              din_ready_o,
  output logic              accel_rst_n_o,
  output logic [DATA_W-1:0] s_axis_tdata_o,
  output logic              s_axis_tvalid_o,
  output logic              s_axis_tlast_o,
  input  logic              s_axis_tready_i,
  input  logic [DATA_W-1:0] m_axis_tdata_i,
  input  logic              m_axis_tvalid_i,
  input  logic              m_axis_tlast_i,
  output logic              m_axis_tready_o,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_valid_o,
  input  logic              dout_read_i,
  output logic [LEN_W-1:0]  out_count_o
);

  // Watchdog is never narrower than the package default width.
  localparam int TW = (cnt_w(TIMEOUT) > TIMEOUT_W) ? cnt_w(TIMEOUT) : TIMEOUT_W;
  localparam int HW = cnt_w(RST_CYCLES);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [TW-1:0]    wd_q, wd_d;
  logic             tlast_seen_q, tlast_seen_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d, arst_n_q, arst_n_d;

  logic feed_s, drain_s, active_s, is_last_s;
  logic in_beat_s, out_beat_s, push_s, pop_s, m_ready_s;
  logic fifo_full_s, fifo_empty_s;

  assign feed_s     = (state_q == ST_FEED);
  assign drain_s    = (state_q == ST_DRAIN);
  assign active_s   = (state_q == ST_HOLD) | feed_s | drain_s;
  assign is_last_s  = (in_cnt_q == len_q - LEN_W'(1));
  assign in_beat_s  = feed_s & din_valid_i & s_axis_tready_i;
  assign m_ready_s  = ~fifo_full_s & (feed_s | drain_s);
  assign out_beat_s = m_axis_tvalid_i & m_ready_s;
  // Beats past the job length are accepted but discarded.
  assign push_s     = out_beat_s & (out_cnt_q < len_q);
  assign pop_s      = dout_read_i & ~fifo_empty_s;

  sync_fifo #(
    .W     (DATA_W),
    .DEPTH (OUT_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .din_i   (m_axis_tdata_i),
    .pop_i   (pop_s),
    .dout_o  (dout_o),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Next-state, counters, watchdog and registered status outputs.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    tlast_seen_d = tlast_seen_q;
    hold_d       = '0;
    wd_d         = '0;

    if (in_beat_s) begin
      in_cnt_d = in_cnt_q + LEN_W'(1);
    end else begin
      in_cnt_d = in_cnt_q;
    end
    if (push_s) begin
      out_cnt_d = out_cnt_q + LEN_W'(1);
    end else begin
      out_cnt_d = out_cnt_q;
    end
    // An early TLAST seen while still feeding ends the job once draining.
    if (out_beat_s && m_axis_tlast_i && feed_s) begin
      tlast_seen_d = 1'b1;
    end else begin
      tlast_seen_d = tlast_seen_q;
    end
    if (state_q == ST_HOLD) begin
      hold_d = hold_q + HW'(1);
    end else begin
      hold_d = '0;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          len_d        = len_i;
          in_cnt_d     = '0;
          out_cnt_d    = '0;
          tlast_seen_d = 1'b0;
          state_d      = (len_i == '0) ? ST_ERR : ST_HOLD;
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        if (hold_q == HW'(RST_CYCLES - 1)) begin
          state_d = ST_FEED;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_FEED: begin
        if (in_beat_s && is_last_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FEED;
        end
      end
      ST_DRAIN: begin
        if (tlast_seen_q || (out_cnt_q == len_q) ||
            (out_beat_s && (m_axis_tlast_i || (out_cnt_q + LEN_W'(1) == len_q)))) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (in_beat_s || out_beat_s || (state_d != state_q) || !active_s) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + TW'(1);
    end
    if (active_s && (state_d == state_q) && (wd_d == TW'(TIMEOUT))) begin
      state_d = ST_ERR;
      wd_d    = '0;
    end else begin
      wd_d = wd_d;
    end

    busy_d   = (state_d == ST_HOLD) | (state_d == ST_FEED) | (state_d == ST_DRAIN);
    done_d   = (state_d == ST_DONE);
    err_d    = (state_d == ST_ERR);
    arst_n_d = (state_d == ST_FEED) | (state_d == ST_DRAIN);
  end

  // State, counter and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      tlast_seen_q <= 1'b0;
      hold_q       <= '0;
      wd_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      arst_n_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      tlast_seen_q <= tlast_seen_d;
      hold_q       <= hold_d;
      wd_q         <= wd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      arst_n_q     <= arst_n_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign accel_rst_n_o   = arst_n_q;
  assign din_ready_o     = feed_s & s_axis_tready_i;
  assign s_axis_tvalid_o = feed_s & din_valid_i;
  assign s_axis_tdata_o  = feed_s ? din_i : '0;
  assign s_axis_tlast_o  = feed_s & is_last_s;
  assign m_axis_tready_o = m_ready_s;
  assign dout_valid_o    = ~fifo_empty_s;
  assign out_count_o     = out_cnt_q;

endmodule

// File: tb/tb_bitrev_job_ctrl.sv
// Directed bench for bitrev_job_ctrl with an echoing accelerator model.
module tb_bitrev_job_ctrl;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int TO = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o, done_o, err_o;
  logic [DW-1:0] din_i = '0;
  logic          din_valid_i = 1'b0;
  logic          din_ready_o, accel_rst_n_o;
  logic [DW-1:0] s_axis_tdata_o;
  logic          s_axis_tvalid_o, s_axis_tlast_o;
  logic          s_axis_tready_i = 1'b1;
  logic [DW-1:0] m_axis_tdata_i = '0;
  logic          m_axis_tvalid_i = 1'b0;
  logic          m_axis_tlast_i = 1'b0;
  logic          m_axis_tready_o;
  logic [DW-1:0] dout_o;
  logic          dout_valid_o;
  logic          dout_read_i = 1'b0;
  logic [LW-1:0] out_count_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit acc_en   = 1'b1;
  logic [32:0] aq[$];
  logic [32:0] head;

  bitrev_job_ctrl #(
    .DATA_W(DW), .LEN_W(LW), .RST_CYCLES(4), .TIMEOUT(TO), .OUT_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .din_i(din_i), .din_valid_i(din_valid_i), .din_ready_o(din_ready_o),
    .accel_rst_n_o(accel_rst_n_o),
    .s_axis_tdata_o(s_axis_tdata_o), .s_axis_tvalid_o(s_axis_tvalid_o),
    .s_axis_tlast_o(s_axis_tlast_o), .s_axis_tready_i(s_axis_tready_i),
    .m_axis_tdata_i(m_axis_tdata_i), .m_axis_tvalid_i(m_axis_tvalid_i),
    .m_axis_tlast_i(m_axis_tlast_i), .m_axis_tready_o(m_axis_tready_o),
    .dout_o(dout_o), .dout_valid_o(dout_valid_o), .dout_read_i(dout_read_i),
    .out_count_o(out_count_o)
  );

  always #5 clk = ~clk;

  // Accelerator model: echoes each input word back, cleared while held in reset.
  always @(posedge clk) begin
    if (rst || !accel_rst_n_o) begin
      aq.delete();
    end else begin
      if (m_axis_tvalid_i && m_axis_tready_o && aq.size() > 0) void'(aq.pop_front());
      if (s_axis_tvalid_o && s_axis_tready_i) aq.push_back({s_axis_tlast_o, s_axis_tdata_o});
    end
    if (acc_en && aq.size() > 0) begin
      head = aq[0];
      m_axis_tvalid_i <= 1'b1;
      m_axis_tdata_i  <= head[31:0];
      m_axis_tlast_i  <= head[32];
    end else begin
      m_axis_tvalid_i <= 1'b0;
      m_axis_tdata_i  <= '0;
      m_axis_tlast_i  <= 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic do_start(input logic [LW-1:0] len);
    @(negedge clk);
    start_i = 1'b1;
    len_i   = len;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic exp_last);
    int k = 0;
    din_i = d;
    din_valid_i = 1'b1;
    #1;
    while (!din_ready_o && k < 64) begin
      @(negedge clk); #1; k++;
    end
    n_checks++;
    if (din_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL send_accept word %0h: got ready %b required 1", d, din_ready_o);
    end
    n_checks++;
    if (s_axis_tlast_o !== exp_last) begin
      n_fail++; $display("FAIL send_tlast word %0h: got %b required %b", d, s_axis_tlast_o, exp_last);
    end
    n_checks++;
    if (s_axis_tdata_o !== d) begin
      n_fail++; $display("FAIL send_data: got %0h required %0h", s_axis_tdata_o, d);
    end
    @(negedge clk);
    din_valid_i = 1'b0;
  endtask

  task automatic read_word(input logic [DW-1:0] exp);
    int k = 0;
    while (!dout_valid_o && k < 64) begin
      @(negedge clk); k++;
    end
    n_checks++;
    if (dout_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL read_valid for %0h: got %b required 1", exp, dout_valid_o);
    end
    n_checks++;
    if (dout_o !== exp) begin
      n_fail++; $display("FAIL read_data: got %0h required %0h", dout_o, exp);
    end
    dout_read_i = 1'b1;
    @(negedge clk);
    dout_read_i = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int k = 0;
    while (!(done_o || err_o) && k < max_cyc) begin
      @(negedge clk); k++;
    end
    n_checks++;
    if (!(done_o || err_o)) begin
      n_fail++; $display("FAIL wait_done: got no done/err after %0d cycles required done", max_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({busy_o, done_o, err_o, din_ready_o, accel_rst_n_o, s_axis_tvalid_o,
         s_axis_tlast_o, m_axis_tready_o, dout_valid_o} !== 9'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 000000000",
        {busy_o, done_o, err_o, din_ready_o, accel_rst_n_o, s_axis_tvalid_o,
         s_axis_tlast_o, m_axis_tready_o, dout_valid_o});
    end
    n_checks++;
    if ({dout_o, s_axis_tdata_o, out_count_o} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %0h/%0h/%0h required 0", dout_o, s_axis_tdata_o, out_count_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_start(16'd4);
    n_checks++;
    if ({busy_o, accel_rst_n_o} !== 2'b10) begin
      n_fail++; $display("FAIL basic_hold: got busy,arst=%b required 10", {busy_o, accel_rst_n_o});
    end
    for (int i = 1; i <= 4; i++) send_word(DW'(i), (i == 4));
    wait_done(64);
    n_checks++;
    if ({done_o, err_o, busy_o, accel_rst_n_o} !== 4'b1000) begin
      n_fail++; $display("FAIL basic_done: got %b required 1000", {done_o, err_o, busy_o, accel_rst_n_o});
    end
    n_checks++;
    if (out_count_o !== 16'd4) begin
      n_fail++; $display("FAIL basic_count: got %0d required 4", out_count_o);
    end
    for (int i = 1; i <= 4; i++) read_word(DW'(i));
    n_checks++;
    if (dout_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_empty: got %b required 0", dout_valid_o);
    end
  endtask

  task automatic test_zero_len();
    do_start(16'd0);
    n_checks++;
    if ({err_o, done_o, busy_o, accel_rst_n_o} !== 4'b1000) begin
      n_fail++; $display("FAIL zero_err: got %b required 1000", {err_o, done_o, busy_o, accel_rst_n_o});
    end
    din_valid_i = 1'b1;
    din_i = 32'hDEAD;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({s_axis_tvalid_o, din_ready_o, accel_rst_n_o, err_o} !== 4'b0001) begin
      n_fail++; $display("FAIL zero_nobeat: got %b required 0001", {s_axis_tvalid_o, din_ready_o, accel_rst_n_o, err_o});
    end
    din_valid_i = 1'b0;
  endtask

  task automatic test_timeout();
    acc_en = 1'b0;
    do_start(16'd3);
    for (int i = 0; i < 3; i++) send_word(32'h50 + DW'(i), (i == 2));
    repeat (TO - 1) @(negedge clk);
    n_checks++;
    if ({err_o, busy_o} !== 2'b01) begin
      n_fail++; $display("FAIL timeout_early: got err,busy=%b required 01", {err_o, busy_o});
    end
    @(negedge clk);
    n_checks++;
    if ({err_o, done_o, busy_o, accel_rst_n_o} !== 4'b1000) begin
      n_fail++; $display("FAIL timeout_err: got %b required 1000", {err_o, done_o, busy_o, accel_rst_n_o});
    end
    n_checks++;
    if (out_count_o !== 16'd0) begin
      n_fail++; $display("FAIL timeout_count: got %0d required 0", out_count_o);
    end
    acc_en = 1'b1;
  endtask

  task automatic test_backpressure();
    do_start(16'd20);
    for (int i = 0; i < 20; i++) send_word(32'h100 + DW'(i), (i == 19));
    repeat (4) @(negedge clk);
    n_checks++;
    if ({m_axis_tready_o, dout_valid_o, done_o, busy_o} !== 4'b0101) begin
      n_fail++; $display("FAIL bp_full: got tready,valid,done,busy=%b required 0101",
        {m_axis_tready_o, dout_valid_o, done_o, busy_o});
    end
    n_checks++;
    if (out_count_o !== 16'd16) begin
      n_fail++; $display("FAIL bp_count16: got %0d required 16", out_count_o);
    end
    for (int i = 0; i < 20; i++) read_word(32'h100 + DW'(i));
    wait_done(64);
    n_checks++;
    if ({done_o, err_o} !== 2'b10) begin
      n_fail++; $display("FAIL bp_done: got done,err=%b required 10", {done_o, err_o});
    end
    n_checks++;
    if ({out_count_o, dout_valid_o} !== {16'd20, 1'b0}) begin
      n_fail++; $display("FAIL bp_final: got count %0d valid %b required 20 0", out_count_o, dout_valid_o);
    end
  endtask

  task automatic test_reset_midjob();
    do_start(16'd8);
    send_word(32'h71, 1'b0);
    send_word(32'h72, 1'b0);
    n_checks++;
    if ({dout_valid_o, out_count_o} !== {1'b1, 16'd1}) begin
      n_fail++; $display("FAIL midrst_pre: got valid %b count %0d required 1 1", dout_valid_o, out_count_o);
    end
    din_valid_i = 1'b1;
    din_i = 32'h73;
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if ({busy_o, done_o, err_o, accel_rst_n_o, s_axis_tvalid_o, din_ready_o,
         m_axis_tready_o, dout_valid_o} !== 8'b0) begin
      n_fail++; $display("FAIL midrst_ctrl: got %b required 00000000",
        {busy_o, done_o, err_o, accel_rst_n_o, s_axis_tvalid_o, din_ready_o, m_axis_tready_o, dout_valid_o});
    end
    n_checks++;
    if ({out_count_o, dout_o, s_axis_tdata_o} !== '0) begin
      n_fail++; $display("FAIL midrst_data: got %0h/%0h/%0h required 0", out_count_o, dout_o, s_axis_tdata_o);
    end
    rst = 1'b0;
    din_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_restart();
    do_start(16'd2);
    send_word(32'h21, 1'b0);
    start_i = 1'b1;
    len_i = 16'd5;
    send_word(32'h22, 1'b1);
    start_i = 1'b0;
    wait_done(64);
    n_checks++;
    if ({done_o, out_count_o} !== {1'b1, 16'd2}) begin
      n_fail++; $display("FAIL ignore_start: got done %b count %0d required 1 2", done_o, out_count_o);
    end
    read_word(32'h21);
    read_word(32'h22);
    do_start(16'd3);
    n_checks++;
    if ({done_o, busy_o, accel_rst_n_o} !== 3'b010) begin
      n_fail++; $display("FAIL restart_hold1: got done,busy,arst=%b required 010", {done_o, busy_o, accel_rst_n_o});
    end
    for (int j = 2; j <= 4; j++) begin
      @(negedge clk);
      n_checks++;
      if (accel_rst_n_o !== 1'b0) begin
        n_fail++; $display("FAIL restart_hold%0d: got %b required 0", j, accel_rst_n_o);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({accel_rst_n_o, din_ready_o} !== 2'b11) begin
      n_fail++; $display("FAIL restart_release: got arst,ready=%b required 11", {accel_rst_n_o, din_ready_o});
    end
    for (int i = 0; i < 3; i++) send_word(32'h31 + DW'(i), (i == 2));
    wait_done(64);
    n_checks++;
    if ({done_o, out_count_o} !== {1'b1, 16'd3}) begin
      n_fail++; $display("FAIL restart_done: got done %b count %0d required 1 3", done_o, out_count_o);
    end
    for (int i = 0; i < 3; i++) read_word(32'h31 + DW'(i));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_timeout();
    test_backpressure();
    test_reset_midjob();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
